lfsr_checker: RTL

Receive-side counterpart of the 8-bit Fibonacci LFSR random source. It consumes the generator's raw byte stream, self-seeds from the first accepted byte, and predicts every following byte with the same polynomial. It declares lock after a run of matches, counts mismatches while locked, and drops lock after a run of consecutive mismatches. It sits on the peripheral bus next to the random source and serves as a built-in self-test for the generator and for any path carrying its output.

---
 rtl/lfsr_checker_pkg.sv | 21 ++
 rtl/lfsr_checker_if.sv | 27 ++
 rtl/lfsr_checker.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the 8-bit Fibonacci LFSR random source and its
// receive-side checker: tap mask, step function and checker state encoding.
package lfsr_checker_pkg;

  // Feedback taps at bits 7,5,4,3 of the 8-bit register.
  localparam logic [7:0] LFSR8_TAPS = 8'hB8;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } lfsr_state_e;

  // One generator step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [7:0] lfsr8_step(input logic [7:0] x);
    return {x[6:0], ^(x & LFSR8_TAPS)};
  endfunction

endpackage : lfsr_checker_pkg

// File: rtl/lfsr_checker_if.sv
// Stream and status bundle between a bus-side driver (master) and the
// lfsr_checker (slave). ERR_W must match the checker's ERR_W.
interface lfsr_checker_if #(
  parameter int ERR_W = 16
);

  logic             clear;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             locked;
  logic             err_pulse;
  logic             lost_pulse;
  logic [ERR_W-1:0] err_count;
  logic             stuck_zero;
  logic [1:0]       state;

  modport master (
    output clear, in_valid, in_data,
    input  locked, err_pulse, lost_pulse, err_count, stuck_zero, state
  );

  modport slave (
    input  clear, in_valid, in_data,
    output locked, err_pulse, lost_pulse, err_count, stuck_zero, state
  );

endinterface : lfsr_checker_if

// File: rtl/lfsr_checker.sv
// Self-seeding checker for the 8-bit LFSR byte stream: acquires, locks after a
// run of matches, counts mismatches while locked and drops lock after a run of
// consecutive mismatches. Define LFSR_CHK_ERRCNT_EN to build the error counter.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  lfsr_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] LOSS_TGT = CNT_W'(LOSS_CNT);

  lfsr_state_e      state_q, state_d;
  logic [7:0]       exp_q, exp_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             lost_pulse_q, lost_pulse_d;
  logic             stuck_zero_q, stuck_zero_d;

`ifdef LFSR_CHK_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
`endif

  logic hit;
  assign hit = (bus.in_data == exp_q);

  // NOTE: every variable is given its hold value before any branch so that no
  // path leaves it unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    match_cnt_d  = match_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    err_pulse_d  = 1'b0;
    lost_pulse_d = 1'b0;

    if (bus.clear) begin
      // A byte arriving together with clear is dropped.
      state_d     = ACQ;
      exp_d       = 8'h00;
      match_cnt_d = '0;
      bad_cnt_d   = '0;
    end else if (bus.in_valid) begin
      unique case (state_q)
        ACQ: begin
          exp_d       = lfsr8_step(bus.in_data);
          match_cnt_d = '0;
          state_d     = SYNC;
        end

        SYNC: begin
          // On a hit in_data equals exp_q, so one expression covers reseed too.
          exp_d = lfsr8_step(bus.in_data);
          if (hit) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_d == LOCK_TGT) begin
              state_d   = LOCK;
              bad_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
          end
        end

        LOCK: begin
          // Flywheel: the predictor free-runs and ignores the input while locked.
          exp_d = lfsr8_step(exp_q);
          if (hit) begin
            bad_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            bad_cnt_d   = bad_cnt_q + 1'b1;
            if (bad_cnt_d == LOSS_TGT) begin
              state_d      = ACQ;
              lost_pulse_d = 1'b1;
              bad_cnt_d    = '0;
            end
          end
        end

        default: begin
          state_d = ACQ;
        end
      endcase
    end

    locked_d     = (state_d == LOCK);
    stuck_zero_d = locked_d && (exp_d == 8'h00);
  end

`ifdef LFSR_CHK_ERRCNT_EN
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.clear) begin
      err_cnt_d = '0;
    end else if (err_pulse_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end
`endif

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACQ;
      exp_q        <= 8'h00;
      match_cnt_q  <= '0;
      bad_cnt_q    <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      lost_pulse_q <= 1'b0;
      stuck_zero_q <= 1'b0;
`ifdef LFSR_CHK_ERRCNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      match_cnt_q  <= match_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      lost_pulse_q <= lost_pulse_d;
      stuck_zero_q <= stuck_zero_d;
`ifdef LFSR_CHK_ERRCNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.lost_pulse = lost_pulse_q;
  assign bus.stuck_zero = stuck_zero_q;
  assign bus.state      = state_q;

`ifdef LFSR_CHK_ERRCNT_EN
  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = '0;
`endif

endmodule : lfsr_checker
